// File: rtl/spi_flash_reader.sv
// SPI flash streaming reader: READ (0x03) + 24-bit address, then N bytes
// out on a valid/ready stream, MISO sample point offset for the input synchroniser.
module spi_flash_reader #(
  parameter int CLK_DIV    = 4,
  parameter int SYNC_FLOPS = 2,
  parameter int LEN_W      = 16,
  parameter int CS_HIGH    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [23:0]      start_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             spi_cs_n,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] ADDR   = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] STALL  = 3'd4;
  localparam logic [2:0] FINISH = 3'd5;

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int HW = $clog2(CS_HIGH + 1);
  localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_SAMP = PW'(CLK_DIV + SYNC_FLOPS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HIGH - 1);

  logic [2:0]       state;
  logic [PW-1:0]    ph;
  logic [4:0]       cnt;
  logic [31:0]      tx;
  logic [7:0]       rx;
  logic [2:0]       rbit;
  logic [LEN_W-1:0] rem;
  logic             pending;
  logic [HW-1:0]    hcnt;

  logic             free;
  logic             samp;
  logic             byte_fin;
  logic             shifting;
  logic             accept;
  logic             ld_new;
  logic             ld_old;
  logic             pend_n;
  logic [7:0]       rx_n;
  logic [2:0]       rbit_n;
  logic [LEN_W-1:0] rem_n;

  assign spi_mosi = tx[31];

  always_comb begin
    free     = !rd_valid || rd_ready;
    shifting = (state == CMD) || (state == ADDR) || (state == DATA);
    samp     = (state == DATA) && (ph == PH_SAMP);
    byte_fin = samp && (rbit == 3'd7);
    accept   = start && (state == IDLE) && !busy;
    rx_n     = {rx[6:0], spi_miso};
    rbit_n   = rbit + {2'b00, samp};
    rem_n    = rem - LEN_W'(byte_fin);
    ld_new   = byte_fin && free;
    ld_old   = pending && free;
    // a finished byte that cannot be handed off waits in rx
    pend_n   = (pending || byte_fin) && !free;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ph       <= '0;
      cnt      <= '0;
      tx       <= '0;
      rx       <= '0;
      rbit     <= '0;
      rem      <= '0;
      pending  <= 1'b0;
      hcnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      done    <= 1'b0;
      pending <= pend_n;
      rem     <= rem_n;
      if (samp) begin
        rx   <= rx_n;
        rbit <= rbit_n;
      end
      if (ld_new) begin
        rd_data  <= rx_n;
        rd_valid <= 1'b1;
      end else if (ld_old) begin
        rd_data  <= rx;
        rd_valid <= 1'b1;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
      if (shifting) begin
        if (ph == PH_LAST) begin
          ph       <= '0;
          spi_sclk <= 1'b0;
        end else begin
          ph <= ph + 1'b1;
          if (ph == PH_RISE) spi_sclk <= 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              state    <= CMD;
              spi_cs_n <= 1'b0;
              tx       <= {8'h03, start_addr};
              rem      <= length;
              ph       <= '0;
              cnt      <= '0;
              rbit     <= '0;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        CMD, ADDR: begin
          if (ph == PH_LAST) begin
            tx  <= {tx[30:0], 1'b0};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd7) state <= ADDR;
            if (cnt == 5'd31) state <= DATA;
          end
        end
        DATA: begin
          if (ph == PH_LAST && rbit_n == 3'd0) begin
            if (pend_n) state <= STALL;
            else if (rem_n == '0) state <= FINISH;
          end
        end
        STALL: begin
          if (free) state <= (rem == '0) ? FINISH : DATA;
        end
        FINISH: begin
          // cs_n rises only once the last byte has left the output register
          if (!spi_cs_n) begin
            if (free) begin
              spi_cs_n <= 1'b1;
              hcnt     <= '0;
            end
          end else if (hcnt == HOLD_LAST) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: flash model with matched sync delay,
// byte scoreboard per instance, directed transactions with literal pins.
module tb_spi_flash_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] start_addr = '0;
  logic [15:0] length = '0;
  logic        rdy = 1'b1;
  logic [7:0]  mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic flash_bit(input logic [23:0] a, input int d);
    logic [23:0] aa;
    logic [7:0]  b;
    aa = a + 24'(d / 8);
    b  = mem[aa[7:0]];
    return b[7 - (d % 8)];
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int CD = (g == 2) ? 5 : 4;
    localparam int SF = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
    logic        busy, done, cs_n, sclk, mosi, miso, rd_valid;
    logic [7:0]  rd_data;
    logic        sclk_q = 1'b0;
    logic        raw = 1'b0;
    logic [3:0]  dly = '0;
    logic [4:0]  ch;
    logic [31:0] cmd = '0;
    int          nrise = 0;

    spi_flash_reader #(
      .CLK_DIV(CD), .SYNC_FLOPS(SF), .LEN_W(16), .CS_HIGH(4)
    ) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .start_addr(start_addr), .length(length),
      .busy(busy), .done(done), .spi_cs_n(cs_n), .spi_sclk(sclk),
      .spi_mosi(mosi), .spi_miso(miso), .rd_data(rd_data),
      .rd_valid(rd_valid), .rd_ready(g == 0 ? rdy : 1'b1)
    );

    assign ch   = {dly, raw};
    assign miso = ch[SF];

    always @(posedge clk) begin
      sclk_q <= sclk;
      dly    <= {dly[2:0], raw};
      if (cs_n) begin
        nrise <= 0;
        raw   <= 1'b0;
      end else if (sclk && !sclk_q) begin
        if (nrise < 32) cmd <= {cmd[30:0], mosi};
        nrise <= nrise + 1;
      end else if (!sclk && sclk_q && nrise >= 32) begin
        raw <= flash_bit(cmd[23:0], nrise - 32);
      end
    end
  end

  logic [7:0]  q0[$], q1[$], q2[$], got0[$];
  logic [23:0] cur_addr = '0;
  logic        exp_busy = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  hold_data = '0;
  logic        sclk_prev = 1'b0;
  int nrise_prev = 0;
  int cyc = 0, rises = 0, first_rise = 0, last_rise = 0;
  int done_cnt = 0, vcnt = 0, n1 = 0, n2 = 0, total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_busy = 1'b0;
      hold     = 1'b0;
    end else begin
      chk("busy", u[0].busy, exp_busy);
      if (u[0].cs_n) chk("sclk_idle", u[0].sclk, 0);
      if (hold) begin
        chk("hold_valid", u[0].rd_valid, 1);
        chk("hold_data", u[0].rd_data, hold_data);
      end
      if (u[0].rd_valid) vcnt++;
      if (u[0].rd_valid && rdy) begin
        if (q0.size() == 0) chk("extra_byte", q0.size(), 1);
        else chk("rd_data", u[0].rd_data, q0.pop_front());
        got0.push_back(u[0].rd_data);
      end
      hold      = u[0].rd_valid && !rdy;
      hold_data = u[0].rd_data;
      if (u[0].done) begin
        done_cnt++;
        chk("done_drained", q0.size(), 0);
      end
      if (u[0].sclk && !sclk_prev) begin
        if (rises == 0) first_rise = cyc;
        last_rise = cyc;
        rises++;
      end
      if (u[0].nrise == 32 && nrise_prev != 32)
        chk("cmd_addr", u[0].cmd, {8'h03, cur_addr});
      if (u[0].done) exp_busy = 1'b0;
      else if (start && !exp_busy) exp_busy = 1'b1;
    end
    sclk_prev  = u[0].sclk;
    nrise_prev = u[0].nrise;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (u[1].rd_valid) begin
        if (q1.size() == 0) chk("u1_extra", q1.size(), 1);
        else chk("u1_data", u[1].rd_data, q1.pop_front());
        n1++;
      end
      if (u[2].rd_valid) begin
        if (q2.size() == 0) chk("u2_extra", q2.size(), 1);
        else chk("u2_data", u[2].rd_data, q2.pop_front());
        n2++;
      end
    end
  end

  task automatic issue(input logic [23:0] addr, input logic [15:0] len);
    logic [23:0] a;
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = addr;
    length     = len;
    cur_addr   = addr;
    for (int i = 0; i < int'(len); i++) begin
      a = addr + 24'(i);
      q0.push_back(mem[a[7:0]]);
      q1.push_back(mem[a[7:0]]);
      q2.push_back(mem[a[7:0]]);
    end
    total    += int'(len);
    rises     = 0;
    done_cnt  = 0;
    vcnt      = 0;
    got0.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_ignored(input logic [23:0] addr, input logic [15:0] len);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = addr;
    length     = len;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (k < budget && (u[0].busy || u[1].busy || u[2].busy)) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("idle_in_budget", k < budget, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int low;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h45] = 8'hA5;
    mem[8'h00] = 8'h11;
    mem[8'h01] = 8'h22;
    mem[8'h02] = 8'h33;
    mem[8'h03] = 8'h44;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", u[0].cs_n, 1);
    chk("rst_sclk", u[0].sclk, 0);
    chk("rst_mosi", u[0].mosi, 0);
    chk("rst_valid", u[0].rd_valid, 0);
    chk("rst_data", u[0].rd_data, 0);
    chk("rst_busy", u[0].busy, 0);
    chk("rst_done", u[0].done, 0);
    reset_n = 1'b1;

    // single byte
    issue(24'h012345, 16'd1);
    wait_idle(3000);
    chk("t1_nbytes", got0.size(), 1);
    chk("t1_byte", got0[0], 8'hA5);
    chk("t1_rises", rises, 40);
    chk("t1_done", done_cnt, 1);
    chk("t1_vcycles", vcnt, 1);

    // four bytes back to back
    issue(24'h000100, 16'd4);
    wait_idle(3000);
    chk("t2_nbytes", got0.size(), 4);
    chk("t2_b0", got0[0], 8'h11);
    chk("t2_b1", got0[1], 8'h22);
    chk("t2_b2", got0[2], 8'h33);
    chk("t2_b3", got0[3], 8'h44);
    chk("t2_rises", rises, 64);
    chk("t2_no_gap", last_rise - first_rise, 63 * 8);
    chk("t2_done", done_cnt, 1);

    // back-pressure stall at a byte boundary
    rdy = 1'b0;
    issue(24'h000100, 16'd3);
    k = 0;
    while (k < 3000 && !u[0].rd_valid) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("t3_first_valid", u[0].rd_valid, 1);
    chk("t3_first_data", u[0].rd_data, 8'h11);
    repeat (100) @(posedge clk);
    #1;
    chk("t3_hold_data", u[0].rd_data, 8'h11);
    chk("t3_stall_sclk", u[0].sclk, 0);
    chk("t3_stall_cs", u[0].cs_n, 0);
    chk("t3_stall_rises", rises, 48);
    rdy = 1'b1;
    wait_idle(3000);
    chk("t3_nbytes", got0.size(), 3);
    chk("t3_b0", got0[0], 8'h11);
    chk("t3_b1", got0[1], 8'h22);
    chk("t3_b2", got0[2], 8'h33);
    chk("t3_rises", rises, 56);
    chk("t3_done", done_cnt, 1);

    // zero length
    issue(24'h000010, 16'd0);
    chk("t4_done_now", u[0].done, 1);
    chk("t4_busy_now", u[0].busy, 1);
    low = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        chk("t4_done_after", u[0].done, 0);
        chk("t4_busy_after", u[0].busy, 0);
      end
      if (!u[0].cs_n) low++;
    end
    chk("t4_cs_low", low, 0);
    chk("t4_done_cnt", done_cnt, 1);

    // reset mid-address
    issue(24'h012345, 16'd1);
    k = 0;
    while (k < 3000 && u[0].nrise != 19) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("t5_reach_bit10", u[0].nrise, 19);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_cs_n", u[0].cs_n, 1);
    chk("t5_sclk", u[0].sclk, 0);
    chk("t5_busy", u[0].busy, 0);
    chk("t5_done", u[0].done, 0);
    chk("t5_valid", u[0].rd_valid, 0);
    q0.delete();
    q1.delete();
    q2.delete();
    total = 0;
    n1    = 0;
    n2    = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt, 0);
    issue(24'h012345, 16'd1);
    wait_idle(3000);
    chk("t5_byte", got0[0], 8'hA5);
    chk("t5_nbytes", got0.size(), 1);

    // start while busy is ignored
    issue(24'h000100, 16'd2);
    repeat (20) @(posedge clk);
    pulse_ignored(24'h000045, 16'd5);
    wait_idle(3000);
    chk("t6_nbytes", got0.size(), 2);
    chk("t6_b0", got0[0], 8'h11);
    chk("t6_b1", got0[1], 8'h22);
    chk("t6_done", done_cnt, 1);

    // address wraps inside the flash
    issue(24'hFFFFFE, 16'd3);
    wait_idle(4000);
    chk("t7_b0", got0[0], 8'hA4);
    chk("t7_b1", got0[1], 8'hA5);
    chk("t7_b2", got0[2], 8'h11);

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);
    chk("sync0_count", n1, total);
    chk("sync3_count", n2, total);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

endmodule
